// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: select-side input beat and registered output beat.
// err_cnt exists only when MUX_N_PIPE_ERRCNT_EN is defined.
interface mux_n_pipe_if #(
   parameter int n = 32,
   parameter int m = 4
);
   localparam int SW = (m > 1) ? $clog2(m) : 1;

   logic [m*n-1:0] in_data;
   logic [SW-1:0]  in_sel;
   logic           in_valid;
   logic           in_ready;
   logic [n-1:0]   out_data;
   logic           out_sel_err;
   logic           out_valid;
   logic           out_ready;
`ifdef MUX_N_PIPE_ERRCNT_EN
   logic [7:0]     err_cnt;

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_sel_err, out_valid, err_cnt
   );
   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_sel_err, out_valid, err_cnt
   );
`else
   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_sel_err, out_valid
   );
   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_sel_err, out_valid
   );
`endif
endinterface

// File: rtl/mux_n_pipe.sv
// N:1 selector with a registered valid/ready output and 2-entry skid buffer.
// Optional saturating out-of-range counter enabled by MUX_N_PIPE_ERRCNT_EN.
module mux_n_pipe #(
   parameter int n = 32,
   parameter int m = 4
) (
   input  logic          clk,
   input  logic          rst,
   mux_n_pipe_if.slave   bus
);
   localparam int        SW    = (m > 1) ? $clog2(m) : 1;
   localparam logic [SW:0] M_LIM = (SW+1)'(m);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [n-1:0]   main_data_q, skid_data_q, cap_data;
   logic           main_err_q, skid_err_q, cap_err;
   logic           in_ready_q;
   logic           accept, deliver;
   logic           load_main, load_skid, main_from_skid;

   // Select is widened by one bit so m=16 still compares correctly.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      cap_data = '0;
      cap_err  = ({1'b0, bus.in_sel} >= M_LIM);
      for (int k = 0; k < m; k++) begin
         if (bus.in_sel == SW'(k)) cap_data = bus.in_data[k*n +: n];
      end
   end

   assign bus.out_valid   = (state_q != EMPTY);
   assign bus.out_data    = main_data_q;
   assign bus.out_sel_err = main_err_q;
   assign bus.in_ready    = in_ready_q;

   assign accept  = bus.in_valid && in_ready_q;
   assign deliver = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d   = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && deliver) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_d   = TWO;
               load_skid = 1'b1;
            end else if (deliver) begin
               state_d   = EMPTY;
            end
         end
         TWO: begin
            if (deliver) begin
               state_d        = ONE;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // in_ready is a function of the next state only, so out_ready never reaches it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         main_data_q <= '0;
         main_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
         if (load_main) begin
            main_data_q <= cap_data;
            main_err_q  <= cap_err;
         end else if (main_from_skid) begin
            main_data_q <= skid_data_q;
            main_err_q  <= skid_err_q;
         end
         if (load_skid) begin
            skid_data_q <= cap_data;
            skid_err_q  <= cap_err;
         end
      end
   end

`ifdef MUX_N_PIPE_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else if (accept && cap_err && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: m=4 main instance plus an m=3 instance for range errors.
// err_cnt checks compile in only with MUX_N_PIPE_ERRCNT_EN.
module tb_mux_n_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   mux_n_pipe_if #(.n(32), .m(4)) bus4 ();
   mux_n_pipe_if #(.n(32), .m(3)) bus3 ();

   mux_n_pipe #(.n(32), .m(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
   mux_n_pipe #(.n(32), .m(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Selected lane carries val, every other lane carries ~val so a wrong select shows up.
   task automatic drive4(input logic [1:0] sel, input logic [31:0] val);
      logic [127:0] d;
      d = {4{~val}};
      d[sel*32 +: 32] = val;
      bus4.in_data  = d;
      bus4.in_sel   = sel;
      bus4.in_valid = 1'b1;
   endtask

   task automatic new_beat(output logic [31:0] exp);
      logic [1:0]   sel;
      logic [127:0] d;
      sel = 2'($urandom_range(0, 3));
      d   = {$urandom, $urandom, $urandom, $urandom};
      exp = d[sel*32 +: 32];
      bus4.in_data  = d;
      bus4.in_sel   = sel;
      bus4.in_valid = 1'b1;
   endtask

   logic [31:0] exp_q[$];
   logic [31:0] pend, dv [4];
   logic        do_acc, do_del;
   int          sent, recv, cyc;

   initial begin
      bus4.in_data = '0; bus4.in_sel = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
      bus3.in_data = '0; bus3.in_sel = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", bus4.out_valid, 0);
      check("rst_out_data", bus4.out_data, 0);
      check("rst_sel_err", bus4.out_sel_err, 0);
      check("rst_in_ready", bus4.in_ready, 1);
`ifdef MUX_N_PIPE_ERRCNT_EN
      check("rst_err_cnt", bus4.err_cnt, 0);
`endif
      rst = 1'b0;

      // 1: sel 0..3 streamed, one-cycle latency, full throughput
      dv[0] = 32'h1111_0000; dv[1] = 32'h2222_0001; dv[2] = 32'h3333_0002; dv[3] = 32'h4444_0003;
      @(negedge clk);
      bus4.in_data  = {dv[3], dv[2], dv[1], dv[0]};
      bus4.in_sel   = 2'd0;
      bus4.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("t1_valid%0d", k), bus4.out_valid, 1);
         check($sformatf("t1_data%0d", k), bus4.out_data, dv[k]);
         check($sformatf("t1_err%0d", k), bus4.out_sel_err, 0);
         check($sformatf("t1_ready%0d", k), bus4.in_ready, 1);
         if (k < 3) bus4.in_sel = 2'(k + 1);
         else       bus4.in_valid = 1'b0;
      end
      @(negedge clk);
      check("t1_drain", bus4.out_valid, 0);

      // 2: out-of-range select on m=3, then last valid code
      bus3.in_data  = '1;
      bus3.in_sel   = 2'b11;
      bus3.in_valid = 1'b1;
      @(negedge clk);
      check("t2_oor_valid", bus3.out_valid, 1);
      check("t2_oor_data", bus3.out_data, 0);
      check("t2_oor_err", bus3.out_sel_err, 1);
`ifdef MUX_N_PIPE_ERRCNT_EN
      check("t2_err_cnt", bus3.err_cnt, 1);
`endif
      bus3.in_sel = 2'b10;
      @(negedge clk);
      bus3.in_valid = 1'b0;
      check("t2_inr_data", bus3.out_data, 32'hFFFF_FFFF);
      check("t2_inr_err", bus3.out_sel_err, 0);

      // 3: stall with three beats, then release
      @(negedge clk);
      bus4.out_ready = 1'b0;
      drive4(2'd1, 32'hAAAA_0001);
      @(negedge clk);
      check("t3_ready_a", bus4.in_ready, 1);
      check("t3_data_a", bus4.out_data, 32'hAAAA_0001);
      drive4(2'd2, 32'hBBBB_0002);
      @(negedge clk);
      check("t3_full", bus4.in_ready, 0);
      check("t3_hold_a1", bus4.out_data, 32'hAAAA_0001);
      drive4(2'd3, 32'hCCCC_0003);
      @(negedge clk);
      check("t3_full2", bus4.in_ready, 0);
      check("t3_hold_a2", bus4.out_data, 32'hAAAA_0001);
      check("t3_hold_v", bus4.out_valid, 1);
      bus4.out_ready = 1'b1;
      @(negedge clk);
      check("t3_data_b", bus4.out_data, 32'hBBBB_0002);
      check("t3_ready_b", bus4.in_ready, 1);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      check("t3_data_c", bus4.out_data, 32'hCCCC_0003);
      @(negedge clk);
      check("t3_drain", bus4.out_valid, 0);

      // 4: 200 random beats, out_ready toggling, scoreboard
      sent = 0; recv = 0; cyc = 0;
      bus4.out_ready = 1'b1;
      new_beat(pend);
      while (recv < 200 && cyc < 4000) begin
         do_acc = bus4.in_valid && bus4.in_ready;
         do_del = bus4.out_valid && bus4.out_ready;
         if (do_del) begin
            if (exp_q.size() == 0) check("t4_extra_beat", 1, 0);
            else                   check("t4_data", bus4.out_data, exp_q.pop_front());
            recv++;
         end
         if (do_acc) begin
            exp_q.push_back(pend);
            sent++;
         end
         @(negedge clk);
         cyc++;
         bus4.out_ready = ~bus4.out_ready;
         if (do_acc) begin
            if (sent < 200) new_beat(pend);
            else            bus4.in_valid = 1'b0;
         end
      end
      check("t4_recv", recv, 200);
      check("t4_left", exp_q.size(), 0);
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // 5: async reset while full
      bus4.out_ready = 1'b0;
      drive4(2'd0, 32'h5555_0001);
      @(negedge clk);
      drive4(2'd1, 32'h5555_0002);
      @(negedge clk);
      check("t5_full", bus4.in_ready, 0);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_valid", bus4.out_valid, 0);
      check("t5_rst_data", bus4.out_data, 0);
      check("t5_rst_err", bus4.out_sel_err, 0);
      check("t5_rst_ready", bus4.in_ready, 1);
      bus4.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus4.out_ready = 1'b1;
      drive4(2'd2, 32'hEEEE_0005);
      @(negedge clk);
      bus4.in_valid = 1'b0;
      check("t5_first_v", bus4.out_valid, 1);
      check("t5_first_d", bus4.out_data, 32'hEEEE_0005);
      @(negedge clk);
      check("t5_drain", bus4.out_valid, 0);

`ifdef MUX_N_PIPE_ERRCNT_EN
      // 6: counter counts then saturates
      check("t6_start", bus3.err_cnt, 0);
      bus3.in_sel   = 2'b11;
      bus3.in_valid = 1'b1;
      repeat (100) @(negedge clk);
      bus3.in_valid = 1'b0;
      check("t6_cnt100", bus3.err_cnt, 100);
      @(negedge clk);
      bus3.in_valid = 1'b1;
      repeat (200) @(negedge clk);
      bus3.in_valid = 1'b0;
      check("t6_sat", bus3.err_cnt, 8'hFF);
      @(negedge clk);
      check("t6_sat_hold", bus3.err_cnt, 8'hFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
